rom_pair_scanner: RTL
=====================

Name: rom_pair_scanner

Overview:
- Read-side master for the 256x8 coefficient ROM.
- Drives the ROM address and chip-select, fetches signed 8-bit entries, and searches all unordered index pairs (i<j) in entries 0..N_ENTRIES-1 for pairs whose signed sum equals a programmable target.
- Each hit is emitted over a valid/ready stream.
- Sits between the ROM and the downstream result logger.

Parameters:
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width; entries are two's-complement signed.
- N_ENTRIES, 8, number of ROM entries scanned, from address 0. Legal range 0..2^ADDR_W.
- CNT_W, 16, width of the hit counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- target  in  DATA_W+1  signed sum to match; latched when start is accepted.
- rom_addr  out  ADDR_W  ROM address.
- rom_cs  out  1  ROM chip-select.
- rom_dout  in  DATA_W  ROM combinational read data.
- hit_valid  out  1  hit available.
- hit_ready  in  1  downstream accepts hit.
- hit_i  out  ADDR_W  lower index of the hit pair.
- hit_j  out  ADDR_W  upper index of the hit pair.
- hit_count  out  CNT_W  hits accepted in the current/last scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0: rom_addr, rom_cs, hit_valid, hit_i, hit_j, hit_count, busy, done. Internal i, j, a_i and target latch are cleared. Reset mid-scan aborts the scan immediately; there is no partial done.
- The ROM read is combinational. rom_addr and rom_cs are driven from registered state/index. rom_dout is sampled at the edge ending the cycle in which the address is presented.
- IDLE:
  - rom_cs=0, rom_addr=0.
  - On start=1: latch target, clear hit_count, set i=0, j=1.
  - If N_ENTRIES<2, go to DONE; otherwise go to LOAD_I.
- LOAD_I:
  - rom_cs=1, rom_addr=i.
  - Capture a_i=rom_dout, then go to SCAN_J.
- SCAN_J:
  - rom_cs=1, rom_addr=j.
  - sum = sign-extend(a_i) + sign-extend(rom_dout), computed at DATA_W+1 bits; it cannot overflow.
  - If sum==target: register hit_i=i, hit_j=j, go to EMIT.
  - Else advance:
    - if j<N_ENTRIES-1: j++.
    - else if i<N_ENTRIES-2: i++, j=i+2 (the new i plus 1), go to LOAD_I.
    - else go to DONE.
- EMIT:
  - rom_cs=0, hit_valid=1.
  - hit_i and hit_j are held stable until hit_valid&&hit_ready.
  - On handshake: hit_count++ (saturating at 2^CNT_W-1), then apply the same advance rule as a SCAN_J miss.
  - hit_valid deasserts in the cycle after the handshake; it is never asserted back-to-back without an intervening SCAN_J.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - hit_count holds its value until the next accepted start.
- busy=1 in LOAD_I, SCAN_J and EMIT; otherwise 0.
- start is ignored while busy or in DONE.
- Latency with no hits and hit_ready tied high:
  - busy cycles = sum over i=0..N-2 of (N-i) (1 load + (N-1-i) compares per i).
  - This is 35 cycles for N=8. done follows in the next cycle.
- Each hit adds 1 EMIT cycle plus any cycles with hit_ready=0.
- Pairs are reported in lexicographic (i,j) order. No pair is reported twice, and i==j is never compared.

Decomposition:
- Shared package (tuple_sum_pkg):
  - scanner state enum {IDLE, LOAD_I, SCAN_J, EMIT, DONE}.
  - ROM_ADDR_W=8 and ROM_DATA_W=8 constants, also used by the ROM wrapper.
- No sub-module is required. The index-advance logic (i/j increment, wrap, end detect) is small enough to stay inline as one combinational "next pair" block shared by SCAN_J-miss and EMIT-handshake.
- The ROM itself is instantiated beside the scanner at the top level, not inside it.

Test Plan:
- Use the standard ROM contents [-5,-2,3,2,0,-5,4,1], N_ENTRIES=8, hit_ready=1.
- target=-1: hits (0,6), (1,7), (5,6) in that order; hit_count=3; done pulses once.
- target=-10: single hit (0,5); hit_count=1.
- target=0: single hit (1,3). target=100: no hit_valid ever; busy high exactly 35 cycles, then done for 1 cycle, hit_count=0.
- target=-1 with hit_ready held low 5 cycles on each hit: hit_i and hit_j stay stable while stalled; the same 3 hits arrive in order; busy extends by exactly 15 cycles.
- Assert rst_n=0 for one cycle during SCAN_J of i=2: next cycle all outputs are 0 and the state is IDLE. A fresh start with target=-1 yields the full 3-hit result.
- Pulse start while busy: the pulse is ignored and the result is unchanged. Build with N_ENTRIES=1: start leads to done on the second cycle, with hit_count=0 and rom_cs never asserted.

Source files
------------

// File: rtl/tuple_sum_pkg.sv
// Shared definitions for the coefficient-ROM pair scanner.
//   scan_state_e : scanner FSM states
//   ROM_ADDR_W / ROM_DATA_W : geometry of the 256x8 coefficient ROM,
//                             shared with the ROM wrapper
package tuple_sum_pkg;

  localparam int ROM_ADDR_W = 8;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    SCAN_J = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } scan_state_e;

endpackage

// File: rtl/rom_pair_scanner.sv
// Read-side master for the coefficient ROM. Walks every unordered index pair
// (i<j) over entries 0..N_ENTRIES-1, adds the two signed entries and streams
// out each pair whose sum equals the target latched at start.
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   start, target        : begin a scan (IDLE only); signed DATA_W+1 target
//   rom_addr, rom_cs     : ROM address / chip-select (decoded from registers)
//   rom_dout             : combinational ROM read data
//   hit_valid/hit_ready  : hit stream handshake; hit_i < hit_j payload
//   hit_count            : saturating count of accepted hits this scan
//   busy, done           : scan in progress / one-cycle end-of-scan pulse
module rom_pair_scanner
  import tuple_sum_pkg::*;
#(
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W,
  parameter int N_ENTRIES = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W:0]   target,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              hit_valid,
  input  logic              hit_ready,
  output logic [ADDR_W-1:0] hit_i,
  output logic [ADDR_W-1:0] hit_j,
  output logic [CNT_W-1:0]  hit_count,
  output logic              busy,
  output logic              done
);

  // Last legal j and i; clamped so degenerate builds still elaborate.
  localparam int LAST_J = (N_ENTRIES >= 1) ? N_ENTRIES - 1 : 0;
  localparam int LAST_I = (N_ENTRIES >= 2) ? N_ENTRIES - 2 : 0;
  localparam logic [ADDR_W-1:0] LAST_J_A = ADDR_W'(LAST_J);
  localparam logic [ADDR_W-1:0] LAST_I_A = ADDR_W'(LAST_I);
  localparam bit HAS_PAIRS = (N_ENTRIES >= 2);

  scan_state_e state, nxt_state;

  logic [ADDR_W-1:0] i, j;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W:0]   tgt_q;

  // Sign-extended add at DATA_W+1 bits; two's-complement wrap never occurs
  // because the extra bit absorbs the carry.
  logic [DATA_W:0] sum;
  logic            match;
  assign sum   = {a_i[DATA_W-1], a_i} + {rom_dout[DATA_W-1], rom_dout};
  assign match = (sum == tgt_q);

  // Next pair: shared by a SCAN_J miss and an EMIT handshake.
  logic [ADDR_W-1:0] adv_i, adv_j;
  scan_state_e       adv_st;
  always_comb begin
    adv_i  = i;
    adv_j  = j;
    adv_st = DONE;
    if (j < LAST_J_A) begin
      adv_j  = j + 1'b1;
      adv_st = SCAN_J;
    end else if (i < LAST_I_A) begin
      adv_i  = i + 1'b1;
      adv_j  = i + ADDR_W'(2);  // new i plus one
      adv_st = LOAD_I;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start) nxt_state = HAS_PAIRS ? LOAD_I : DONE;
      LOAD_I:  nxt_state = SCAN_J;
      SCAN_J:  nxt_state = match ? EMIT : adv_st;
      EMIT:    if (hit_ready) nxt_state = adv_st;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i         <= '0;
      j         <= '0;
      a_i       <= '0;
      tgt_q     <= '0;
      hit_i     <= '0;
      hit_j     <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tgt_q     <= target;
          hit_count <= '0;
          i         <= '0;
          j         <= ADDR_W'(1);
        end
        LOAD_I: a_i <= rom_dout;
        SCAN_J: begin
          if (match) begin
            hit_i <= i;
            hit_j <= j;
          end else begin
            i <= adv_i;
            j <= adv_j;
          end
        end
        EMIT: if (hit_ready) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
          i <= adv_i;
          j <= adv_j;
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state/index
  always_comb begin
    rom_cs    = 1'b0;
    rom_addr  = '0;
    hit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD_I: begin rom_cs = 1'b1; rom_addr = i; busy = 1'b1; end
      SCAN_J: begin rom_cs = 1'b1; rom_addr = j; busy = 1'b1; end
      EMIT:   begin hit_valid = 1'b1; busy = 1'b1; end
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

endmodule
